// File: rtl/onewire_master_trx.sv
// Open-drain single-wire master transceiver.
// Sends a framed command (start, payload LSB first, even parity, stop) and
// optionally receives a response frame with timeout, parity and framing checks.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | bus released, waiting for i_tx_start
// TX_START | driving start bit (low)
// TX_DATA  | sending payload bits, LSB first
// TX_PAR   | sending even-parity bit
// TX_STOP  | stop bit (released); o_tx_done in its last cycle
// RX_WAIT  | waiting for response start edge, timeout timer running
// RX_START | confirming start bit at mid-bit
// RX_DATA  | sampling payload bits at mid-bit
// RX_PAR   | sampling parity bit
// RX_STOP  | sampling stop bit
module onewire_master_trx #(
  parameter int DATA_W      = 56,
  parameter int CLK_PER_BIT = 16,
  parameter int RSP_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_start,
  input  logic              i_expect_rsp,
  inout  wire               bus,
  output logic              o_busy,
  output logic              o_tx_done,
  output logic              o_rx_valid,
  output logic [DATA_W-1:0] o_command,
  output logic              o_error,
  output logic [1:0]        o_err_code
);

  localparam int BIT_W = $clog2(CLK_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam int TO_W  = $clog2(RSP_TIMEOUT + 1);

  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(RSP_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP,
    RX_WAIT, RX_START, RX_DATA, RX_PAR, RX_STOP
  } state_t;

  state_t state, next_state;

  logic [BIT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  idx;
  logic [TO_W-1:0]   to_cnt;
  logic [DATA_W-1:0] shift;
  logic              par;
  logic              rsp_pending;
  logic              bus_s1, bus_s2;
  logic              rx_valid_q, error_q;
  logic              drive_low;

  logic bit_tc, idx_tc, to_tc, done_q, rx_par_bad;

  assign bit_tc     = (bit_cnt == '0);
  assign idx_tc     = (idx == '0);
  assign to_tc      = (to_cnt == '0);
  // A result pulse holds the FSM in its RX state for one extra cycle so
  // o_busy is still high while o_rx_valid / o_error is visible.
  assign done_q     = rx_valid_q | error_q;
  assign rx_par_bad = (^shift) ^ bus_s2;

  assign bus = drive_low ? 1'b0 : 1'bz;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (i_tx_start) next_state = TX_START;
      TX_START: if (bit_tc) next_state = TX_DATA;
      TX_DATA:  if (bit_tc && idx_tc) next_state = TX_PAR;
      TX_PAR:   if (bit_tc) next_state = TX_STOP;
      TX_STOP:  if (bit_tc) next_state = rsp_pending ? RX_WAIT : IDLE;
      RX_WAIT: begin
        if (done_q) next_state = IDLE;
        else if (!to_tc && !bus_s2) next_state = RX_START;
      end
      RX_START: if (bit_tc) next_state = bus_s2 ? RX_WAIT : RX_DATA;
      RX_DATA:  if (bit_tc && idx_tc) next_state = RX_PAR;
      RX_PAR: begin
        if (done_q) next_state = IDLE;
        else if (bit_tc && !rx_par_bad) next_state = RX_STOP;
      end
      RX_STOP:  if (done_q) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Moore outputs: bus drive, busy, TX completion
  always_comb begin
    drive_low = 1'b0;
    o_busy    = (state != IDLE);
    o_tx_done = 1'b0;
    case (state)
      TX_START: drive_low = 1'b1;
      TX_DATA:  drive_low = ~shift[0];
      TX_PAR:   drive_low = ~par;
      TX_STOP:  o_tx_done = bit_tc;
      default:  drive_low = 1'b0;
    endcase
  end

  // Input synchroniser; idles high like the released line
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_s1 <= 1'b1;
      bus_s2 <= 1'b1;
    end else begin
      bus_s1 <= bus;
      bus_s2 <= bus_s1;
    end
  end

  // Bit timer, index, timeout timer, shift register and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      idx         <= '0;
      to_cnt      <= '0;
      shift       <= '0;
      par         <= 1'b0;
      rsp_pending <= 1'b0;
      rx_valid_q  <= 1'b0;
      error_q     <= 1'b0;
      o_command   <= '0;
      o_err_code  <= 2'b00;
    end else begin
      rx_valid_q <= 1'b0;
      error_q    <= 1'b0;

      if (state != next_state || bit_tc)
        bit_cnt <= (next_state == RX_START) ? HALF_LAST : BIT_LAST;
      else
        bit_cnt <= bit_cnt - 1'b1;

      case (state)
        IDLE: begin
          if (i_tx_start) begin
            shift       <= i_tx_data;
            par         <= ^i_tx_data;
            rsp_pending <= i_expect_rsp;
          end
        end
        TX_START: idx <= IDX_LAST;
        TX_DATA: begin
          if (bit_tc) begin
            shift <= shift >> 1;
            idx   <= idx - 1'b1;
          end
        end
        TX_STOP: if (bit_tc) to_cnt <= TO_LAST;
        RX_WAIT: begin
          if (!done_q) begin
            if (to_tc) begin
              error_q    <= 1'b1;
              o_err_code <= 2'b01;
            end else begin
              to_cnt <= to_cnt - 1'b1;
            end
          end
        end
        RX_START: idx <= IDX_LAST;
        RX_DATA: begin
          if (bit_tc) begin
            shift <= {bus_s2, shift[DATA_W-1:1]};
            idx   <= idx - 1'b1;
          end
        end
        RX_PAR: begin
          if (!done_q && bit_tc && rx_par_bad) begin
            error_q    <= 1'b1;
            o_err_code <= 2'b10;
          end
        end
        RX_STOP: begin
          if (!done_q && bit_tc) begin
            if (!bus_s2) begin
              error_q    <= 1'b1;
              o_err_code <= 2'b11;
            end else begin
              o_command  <= shift;
              rx_valid_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rx_valid = rx_valid_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_onewire_master_trx.sv
// Self-checking bench for onewire_master_trx: frame-level reference model
// plus a bit-banged slave that answers on the shared open-drain line.
module tb_onewire_master_trx;

  localparam int DW        = 8;
  localparam int CPB       = 4;
  localparam int TO        = 64;
  localparam int FRAME_CYC = (DW + 3) * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] i_tx_data = '0;
  logic          i_tx_start = 1'b0;
  logic          i_expect_rsp = 1'b0;
  wire           bus;
  logic          o_busy, o_tx_done, o_rx_valid, o_error;
  logic [DW-1:0] o_command;
  logic [1:0]    o_err_code;
  logic          slave_low = 1'b0;

  pullup (bus);
  assign bus = slave_low ? 1'b0 : 1'bz;

  onewire_master_trx #(
    .DATA_W(DW), .CLK_PER_BIT(CPB), .RSP_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .i_tx_data(i_tx_data), .i_tx_start(i_tx_start),
    .i_expect_rsp(i_expect_rsp), .bus(bus), .o_busy(o_busy), .o_tx_done(o_tx_done),
    .o_rx_valid(o_rx_valid), .o_command(o_command), .o_error(o_error),
    .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mdl_cmd  = '0;
  logic [1:0]    mdl_code = 2'b00;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One command exchange; the expected bus waveform and outcome come from
  // the frame rules, not from the design's internals.
  task automatic exchange(input logic [DW-1:0] data, input bit exp_rsp, input bit slave_en,
                          input int delay, input logic [DW-1:0] rsp, input bit bad_par,
                          input bit stop_low, input bit second_start, input bit glitch);
    logic [DW+2:0] tx_frame, rx_frame;
    logic [DW-1:0] cmd_seen;
    logic [1:0]    code_seen, exp_code;
    int            s_start, pulse_c, busy_fall, n_valid, n_err, dec_bit, win;
    bit            done_seen, exp_valid, exp_err;

    tx_frame  = {1'b1, ^data, data, 1'b0};
    rx_frame  = {~stop_low, (^rsp) ^ bad_par, rsp, 1'b0};
    s_start   = FRAME_CYC + 1 + delay;
    pulse_c   = 0; busy_fall = 0; n_valid = 0; n_err = 0; done_seen = 0;
    cmd_seen  = '0; code_seen = 2'b00;
    exp_valid = 0; exp_err = 0; exp_code = mdl_code; dec_bit = 0;
    if (exp_rsp) begin
      if (!slave_en)     begin exp_err = 1; exp_code = 2'b01; end
      else if (bad_par)  begin exp_err = 1; exp_code = 2'b10; dec_bit = DW + 1; end
      else if (stop_low) begin exp_err = 1; exp_code = 2'b11; dec_bit = DW + 2; end
      else               begin exp_valid = 1; dec_bit = DW + 2; end
    end

    @(negedge clk);
    i_tx_data = data; i_expect_rsp = exp_rsp; i_tx_start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c <= FRAME_CYC) begin
        chk("tx_bus", bus, tx_frame[(c-1)/CPB]);
        chk("tx_busy", o_busy, 1'b1);
      end else if (!slave_low) begin
        chk("bus_released", bus, 1'b1);
      end
      chk("tx_done", o_tx_done, (c == FRAME_CYC));
      if (o_rx_valid) begin n_valid++; pulse_c = c; cmd_seen = o_command; end
      if (o_error) begin n_err++; pulse_c = c; code_seen = o_err_code; cmd_seen = o_command; end
      if (!o_busy) begin busy_fall = c; done_seen = 1; break; end
      if (c == 1) i_tx_start = 1'b0;
      if (second_start && c == 10) begin
        i_tx_start = 1'b1; i_tx_data = ~data; i_expect_rsp = ~exp_rsp;
      end
      if (second_start && c == 11) i_tx_start = 1'b0;
      slave_low = 1'b0;
      if (slave_en && c >= s_start && c < s_start + FRAME_CYC)
        slave_low = ~rx_frame[(c - s_start) / CPB];
      if (glitch && c == FRAME_CYC + 5) slave_low = 1'b1;
    end
    slave_low = 1'b0; i_tx_start = 1'b0;

    chk("exchange_end", done_seen, 1'b1);
    chk("n_valid", n_valid, exp_valid);
    chk("n_error", n_err, exp_err);
    if (exp_valid) begin
      chk("rx_cmd", cmd_seen, rsp);
      mdl_cmd = rsp;
    end
    if (exp_err) begin
      chk("err_code", code_seen, exp_code);
      chk("cmd_kept_on_err", cmd_seen, mdl_cmd);
      mdl_code = exp_code;
    end
    if (!exp_rsp) begin
      chk("busy_fall_tx", busy_fall, FRAME_CYC + 1);
    end else begin
      chk("busy_fall", busy_fall, pulse_c + 1);
      if (!slave_en) begin
        chk("timeout_at", pulse_c, FRAME_CYC + 1 + TO);
      end else begin
        win = s_start + dec_bit * CPB;
        chk("pulse_in_window", (pulse_c > win && pulse_c <= win + CPB + 2), 1'b1);
      end
    end
    chk("cmd_hold", o_command, mdl_cmd);
    chk("code_hold", o_err_code, mdl_code);
  endtask

  // Abort a frame with reset in the middle of the payload
  task automatic reset_mid_frame();
    bit any_pulse, any_busy, any_low;
    any_pulse = 0; any_busy = 0; any_low = 0;
    @(negedge clk);
    i_tx_data = DW'($urandom); i_expect_rsp = 1'b1; i_tx_start = 1'b1;
    @(negedge clk);
    i_tx_start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_bus", bus, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_tx_done", o_tx_done, 1'b0);
    chk("rst_rx_valid", o_rx_valid, 1'b0);
    chk("rst_error", o_error, 1'b0);
    chk("rst_err_code", o_err_code, 2'b00);
    chk("rst_command", o_command, '0);
    reset = 1'b0;
    mdl_cmd = '0; mdl_code = 2'b00;
    repeat (120) begin
      @(negedge clk);
      if (o_tx_done || o_rx_valid || o_error) any_pulse = 1;
      if (o_busy) any_busy = 1;
      if (bus !== 1'b1) any_low = 1;
    end
    chk("post_rst_no_pulse", any_pulse, 1'b0);
    chk("post_rst_idle", any_busy, 1'b0);
    chk("post_rst_bus_free", any_low, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d, r;
    int kind;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_bus", bus, 1'b1);
    chk("reset_cmd", o_command, '0);
    chk("reset_code", o_err_code, 2'b00);
    chk("reset_pulses", {o_tx_done, o_rx_valid, o_error}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    exchange(8'hA5, 0, 0, 0, '0, 0, 0, 0, 0);
    exchange(8'hA5, 0, 0, 0, '0, 0, 0, 1, 0);
    exchange(DW'($urandom), 1, 1, 20, 8'h3C, 0, 0, 0, 0);
    exchange(DW'($urandom), 1, 0, 0, '0, 0, 0, 0, 0);
    exchange(DW'($urandom), 1, 1, 10, 8'h01, 1, 0, 0, 0);
    exchange(DW'($urandom), 1, 1, 12, 8'h5A, 0, 1, 0, 0);
    exchange(DW'($urandom), 1, 1, 20, 8'hC3, 0, 0, 0, 1);

    for (int i = 0; i < 10; i++) begin
      d = DW'($urandom);
      r = DW'($urandom);
      kind = $urandom_range(0, 4);
      exchange(d, kind != 0, kind >= 2, $urandom_range(0, 30), r,
               kind == 3, kind == 4, 0, 0);
    end

    reset_mid_frame();
    exchange(DW'($urandom), 1, 1, 5, 8'h96, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/onewire_master_trx.md
ONEWIRE_MASTER_TRX -- requirements
Module: onewire_master_trx

Interface
REQ-001 SHALL have parameter DATA_W, default 56, frame payload width in bits (legal 8..64).
REQ-002 SHALL have parameter CLK_PER_BIT, default 16, clock cycles per bit period (even, >=4).
REQ-003 SHALL have parameter RSP_TIMEOUT, default 1024, cycles allowed from end of TX stop bit to RX start-bit detection.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_tx_data  input  DATA_W  command payload; sampled only on an accepted start.
REQ-007 SHALL have port i_tx_start  input  1  single-cycle start request.
REQ-008 SHALL have port i_expect_rsp  input  1  sampled with i_tx_start; 1 = receive a response frame after TX.
REQ-009 SHALL have port bus  inout  1  open-drain line: driven 0 or released (high-Z); never driven 1.
REQ-010 SHALL have port o_busy  output  1  high from accepted start until return to IDLE.
REQ-011 SHALL have port o_tx_done  output  1  one-cycle pulse when TX stop bit completes.
REQ-012 SHALL have port o_rx_valid  output  1  one-cycle pulse when o_command updated with a good response.
REQ-013 SHALL have port o_command  output  DATA_W  last good received payload.
REQ-014 SHALL have port o_error  output  1  one-cycle pulse on any receive failure.
REQ-015 SHALL have port o_err_code  output  2  cause of last error: 01 timeout, 10 parity, 11 framing; held until next error.

Function
REQ-016 Frame SHALL be: start bit (0), DATA_W data bits LSB first, even-parity bit over data, stop bit (1); each bit lasts exactly CLK_PER_BIT cycles.
REQ-017 Bit value 0 SHALL be sent by driving bus low; 1 by releasing bus.
REQ-018 FSM states SHALL be IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_PAR, RX_STOP.
REQ-019 i_tx_start in IDLE SHALL be accepted: payload latched, o_busy=1 and bus driven low in the next cycle (TX_START).
REQ-020 i_tx_start while o_busy=1 SHALL be ignored with no effect on the frame in progress.
REQ-021 TX frame SHALL occupy exactly (DATA_W+3)*CLK_PER_BIT cycles; o_tx_done pulses in the last TX_STOP cycle.
REQ-022 After TX_STOP: i_expect_rsp latched 0 -> IDLE; latched 1 -> RX_WAIT with bus released.
REQ-023 Bus input SHALL pass through a 2-flop synchroniser; all RX decisions use the synchronised value.
REQ-024 RX_WAIT SHALL count cycles; synchronised low seen -> RX_START; count reaching RSP_TIMEOUT first -> o_error, o_err_code=01, IDLE.
REQ-025 RX_START SHALL re-sample at CLK_PER_BIT/2; high there (glitch) -> return to RX_WAIT with timeout counter not reset.
REQ-026 Data, parity and stop bits SHALL each be sampled once at mid-bit (CLK_PER_BIT/2 cycles after bit start), shifted in LSB first.
REQ-027 Parity mismatch SHALL give o_err_code=10; stop bit sampled low SHALL give 11; parity checked before stop, first failure wins; both end in o_error pulse and IDLE.
REQ-028 Good frame SHALL update o_command and pulse o_rx_valid in the same cycle, at the stop-bit mid sample, then IDLE.
REQ-029 o_command SHALL be unchanged on any error.
REQ-030 o_busy SHALL drop the cycle after o_tx_done (no response) or after o_rx_valid/o_error.
REQ-031 Module SHALL never drive bus low while in any RX state or IDLE.

Reset
REQ-032 reset SHALL, on the next clock edge, force IDLE, release bus, and clear o_busy, o_tx_done, o_rx_valid, o_error, o_err_code, o_command and all counters/shift registers to 0.
REQ-033 reset mid-frame SHALL abort without any done/valid/error pulse; synchroniser flops SHALL reset to 1.

Verification (DATA_W=8, CLK_PER_BIT=4, RSP_TIMEOUT=64)
REQ-034 TX only: i_tx_data=8'hA5, i_expect_rsp=0, start -> bus low pattern start,1,0,1,0,0,1,0,1, parity 0, stop 1; o_tx_done at cycle 44; o_busy low at 45.
REQ-035 Round trip: start with i_expect_rsp=1; slave model returns 8'h3C, parity 0, after 20 cycles -> o_rx_valid pulse, o_command=8'h3C, o_error never asserted.
REQ-036 Timeout: i_expect_rsp=1, no response -> o_error pulse 64 cycles after RX_WAIT entry, o_err_code=01, o_command unchanged.
REQ-037 Bad parity: response 8'h01 with parity 0 -> o_error, o_err_code=10, no o_rx_valid; then stop low on next exchange -> o_err_code=11.
REQ-038 Busy/reset: second i_tx_start mid-frame ignored (bus waveform identical to REQ-034); reset asserted mid-TX_DATA -> bus released next cycle, all outputs 0, no pulses.
